// File: rtl/pipelined_adder.sv
// Segmented ripple-carry adder/subtractor: one SEGMENT-bit slice per stage, carry
// registered between stages, valid/ready on both sides. ADDER_OVERFLOW_EN adds the overflow port.
module pipelined_adder #(
    parameter int WIDTH   = 16,
    parameter int SEGMENT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out
`ifdef ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int STAGES = WIDTH / SEGMENT;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [STAGES-1:0] sub_q, sub_d;
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [WIDTH:0]   slice_res;

`ifdef ADDER_OVERFLOW_EN
    logic ovf_q, ovf_d;
`endif

    // Adds slice k of x and y into acc; returns {slice carry, acc with slice k filled}.
    function automatic logic [WIDTH:0] add_slice(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] acc,
        input logic             cin,
        input int               k
    );
        logic [SEGMENT:0] s;
        logic [WIDTH-1:0] r;
        s = {1'b0, x[k*SEGMENT +: SEGMENT]} + {1'b0, y[k*SEGMENT +: SEGMENT]}
          + {{SEGMENT{1'b0}}, cin};
        r = acc;
        r[k*SEGMENT +: SEGMENT] = s[SEGMENT-1:0];
        return {s[SEGMENT], r};
    endfunction

    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? ~carry_in : carry_in;

    always_comb begin
        adv       = !valid_q[STAGES-1] || out_ready;
        valid_d   = valid_q;
        carry_d   = carry_q;
        sub_d     = sub_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        sum_d     = sum_q;
        slice_res = '0;
`ifdef ADDER_OVERFLOW_EN
        ovf_d     = ovf_q;
`endif
        // Global enable: every stage, bubbles included, moves or holds together.
        if (adv) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                slice_res  = add_slice(a, b_eff, '0, cin_eff, 0);
                carry_d[0] = slice_res[WIDTH];
                sum_d[0]   = slice_res[WIDTH-1:0];
                opa_d[0]   = a;
                opb_d[0]   = b_eff;
                sub_d[0]   = sub;
            end
            for (int k = 1; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    slice_res  = add_slice(opa_q[k-1], opb_q[k-1], sum_q[k-1], carry_q[k-1], k);
                    carry_d[k] = slice_res[WIDTH];
                    sum_d[k]   = slice_res[WIDTH-1:0];
                    opa_d[k]   = opa_q[k-1];
                    opb_d[k]   = opb_q[k-1];
                    sub_d[k]   = sub_q[k-1];
                end
            end
`ifdef ADDER_OVERFLOW_EN
            // Same-sign operands producing an opposite-sign result == MSB carry-in XOR carry-out.
            if (valid_d[STAGES-1]) begin
                ovf_d = (opa_d[STAGES-1][WIDTH-1] == opb_d[STAGES-1][WIDTH-1])
                     && (sum_d[STAGES-1][WIDTH-1] != opa_d[STAGES-1][WIDTH-1]);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            carry_q <= '0;
            sub_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                sum_q[k] <= '0;
            end
`ifdef ADDER_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
`ifdef ADDER_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = adv;
    assign out_valid = valid_q[STAGES-1];
    assign out       = sum_q[STAGES-1];
    // Subtract reports borrow, the inverse of the raw carry.
    assign carry_out = carry_q[STAGES-1] ^ sub_q[STAGES-1];
`ifdef ADDER_OVERFLOW_EN
    assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomized self-checking bench for pipelined_adder against an arithmetic reference
// model with a valid/ready pipeline occupancy model. Honors ADDER_OVERFLOW_EN.
module tb_pipelined_adder;

    localparam int W      = 16;
    localparam int SEG    = 4;
    localparam int STAGES = W / SEG;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic         carry_out;
`ifdef ADDER_OVERFLOW_EN
    logic         overflow;
`endif

    pipelined_adder #(.WIDTH(W), .SEGMENT(SEG)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .carry_out (carry_out)
`ifdef ADDER_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [W-1:0] o;
        logic         co;
        logic         ovf;
    } slot_t;

    slot_t pipe [STAGES];
    int    err_cnt = 0;
    int    chk_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic slot_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic ci, input logic s);
        slot_t  res;
        longint m, ux, uy, c, r, r2, sx, sy, sr;
        m  = longint'(1) << W;
        ux = longint'(x);
        uy = longint'(y);
        c  = ci ? 1 : 0;
        r  = s ? (ux - uy - c) : (ux + uy + c);
        r2 = ((r % m) + m) % m;
        sx = x[W-1] ? ux - m : ux;
        sy = y[W-1] ? uy - m : uy;
        sr = s ? (sx - sy - c) : (sx + sy + c);
        res.v   = 1'b1;
        res.o   = r2[W-1:0];
        res.co  = s ? (r < 0) : (r >= m);
        res.ovf = (sr > (m / 2) - 1) || (sr < -(m / 2));
        return res;
    endfunction

    // One clock: drive at negedge, compare outputs with the model, then advance the model
    // exactly as the coming rising edge will.
    task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s, input logic ordy, input logic rst);
        logic adv_m;
        @(negedge clk);
        reset     = rst;
        in_valid  = v;
        a         = x;
        b         = y;
        carry_in  = ci;
        sub       = s;
        out_ready = ordy;
        #1;
        adv_m = !pipe[STAGES-1].v || ordy;
        check("out_valid", 64'(out_valid), 64'(pipe[STAGES-1].v));
        check("in_ready", 64'(in_ready), 64'(adv_m));
        if (pipe[STAGES-1].v) begin
            check("out", 64'(out), 64'(pipe[STAGES-1].o));
            check("carry_out", 64'(carry_out), 64'(pipe[STAGES-1].co));
`ifdef ADDER_OVERFLOW_EN
            check("overflow", 64'(overflow), 64'(pipe[STAGES-1].ovf));
`endif
        end
        if (rst) begin
            for (int k = 0; k < STAGES; k++) pipe[k] = '{v: 1'b0, o: '0, co: 1'b0, ovf: 1'b0};
        end else if (adv_m) begin
            for (int k = STAGES - 1; k > 0; k--) pipe[k] = pipe[k-1];
            if (v) pipe[0] = ref_op(x, y, ci, s);
            else   pipe[0] = '{v: 1'b0, o: '0, co: 1'b0, ovf: 1'b0};
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
        step(1'b1, x, y, ci, s, 1'b1, 1'b0);
    endtask

    logic [W-1:0] rx, ry;

    initial begin
        for (int k = 0; k < STAGES; k++) pipe[k] = '{v: 1'b0, o: '0, co: 1'b0, ovf: 1'b0};

        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("reset_out", 64'(out), 64'(0));
        check("reset_carry", 64'(carry_out), 64'(0));
`ifdef ADDER_OVERFLOW_EN
        check("reset_ovf", 64'(overflow), 64'(0));
`endif

        // Basic add; the model pins out_valid to exactly STAGES edges after accept.
        op(16'h1234, 16'h4321, 1'b0, 1'b0);
        idle(STAGES + 1);

        // Full-length carry/borrow chains and wrap-around.
        op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        op(16'h0005, 16'h0007, 1'b1, 1'b1);
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op(16'h0000, 16'h0001, 1'b0, 1'b1);
        idle(STAGES + 1);

        // Signed overflow corners.
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op(16'h8000, 16'h0001, 1'b0, 1'b1);
        op(16'h8000, 16'h8000, 1'b0, 1'b0);
        idle(STAGES + 1);

        // Back-to-back stream.
        for (int i = 0; i < 16; i++) begin
            rx = W'($urandom_range(0, 65535));
            ry = W'($urandom_range(0, 65535));
            op(rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(STAGES + 1);

        // Backpressure for 5 cycles mid-stream with in_valid held high.
        for (int i = 0; i < 6; i++) begin
            rx = W'($urandom_range(0, 65535));
            ry = W'($urandom_range(0, 65535));
            op(rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 5; i++) begin
            rx = W'($urandom_range(0, 65535));
            ry = W'($urandom_range(0, 65535));
            step(1'b1, rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        idle(STAGES + 2);

        // Reset with three operations in flight.
        op(16'h1111, 16'h2222, 1'b0, 1'b0);
        op(16'h3333, 16'h4444, 1'b1, 1'b0);
        op(16'h5555, 16'h6666, 1'b0, 1'b1);
        step(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(STAGES);
        op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        idle(STAGES + 1);

        // Random valid/ready traffic.
        for (int i = 0; i < 300; i++) begin
            rx = W'($urandom_range(0, 65535));
            ry = W'($urandom_range(0, 65535));
            step(1'($urandom_range(0, 3) != 0), rx, ry, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0);
        end
        idle(STAGES + 2);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
